multi_clk_divider: RTL and testbench

Parametrised, multi-channel successor to the single 12 MHz step-down divider. It generates NUM_CH independent divided clocks plus a one-cycle tick per output rising edge. Each channel's divisor is runtime-programmable with glitch-free reload, and channels have individual enables and a common phase-restart. It sits between the 12 MHz board clock and slow consumers: keypad scan, display refresh, debounce, and Nios-side timebases.

---
 rtl/multi_clk_divider.sv | 49 ++++
 tb/tb_multi_clk_divider.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/multi_clk_divider.sv
// multi_clk_divider: NUM_CH programmable 50 % duty clock dividers with per-rise ticks.
// Divisors reload only at half-period boundaries, so no runt pulses reach the outputs.
module multi_clk_divider #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 20,
  parameter int DIV_RESET = 100000,
  parameter int CH_W      = 2
) (
  input  logic              clk_12m_in,
  input  logic              reset_b,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_restart,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick_out
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d, shd_q, shd_d, act_q, act_d;
    logic clk_q, clk_d, tck_q, tck_d, idle, hit;
    // shd_d doubles as the bypass value, so a write on a reload edge is used at once
    always_comb begin
      shd_d = (wr_en && wr_ch == CH_W'(i)) ? wr_div : shd_q;
      idle  = sync_restart || !ch_en[i] || act_q == '0;
      hit   = cnt_q == act_q - CNT_W'(1);
      cnt_d = (idle || hit) ? '0 : cnt_q + CNT_W'(1);
      clk_d = idle ? 1'b0 : clk_q ^ hit;
      tck_d = !idle && hit && !clk_q;
      act_d = (idle || hit) ? shd_d : act_q;
    end
    always_ff @(posedge clk_12m_in or negedge reset_b)
      if (!reset_b) begin
        cnt_q <= '0;
        shd_q <= CNT_W'(DIV_RESET);
        act_q <= CNT_W'(DIV_RESET);
        clk_q <= 1'b0;
        tck_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        shd_q <= shd_d;
        act_q <= act_d;
        clk_q <= clk_d;
        tck_q <= tck_d;
      end
    assign clk_out[i]  = clk_q;
    assign tick_out[i] = tck_q;
  end
endmodule

// File: tb/tb_multi_clk_divider.sv
// tb_multi_clk_divider: directed and table-driven checks of the multi-channel divider.
module tb_multi_clk_divider;
  logic       clk = 1'b0, rst_b = 1'b0, wr_en = 1'b0, sync = 1'b0;
  logic [1:0] wr_ch = '0;
  logic [7:0] wr_div = '0;
  logic [2:0] ch_en = 3'b111;
  logic [2:0] clk_out, tick_out;
  int n_cmp = 0, n_bad = 0;
  int rise [3];

  typedef struct {int div; int rise; int hi; int lo; int tk;} vec_t;
  vec_t tbl [4];

  always #5 clk = ~clk;

  multi_clk_divider #(.NUM_CH(3), .CNT_W(8), .DIV_RESET(20), .CH_W(2)) dut (
    .clk_12m_in(clk), .reset_b(rst_b), .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
    .ch_en(ch_en), .sync_restart(sync), .clk_out(clk_out), .tick_out(tick_out)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_lvl(input int ch, input logic lvl, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (clk_out[ch] !== lvl && n < 200);
  endtask

  task automatic wr(input int ch, input int d);
    wr_ch = 2'(ch);
    wr_div = 8'(d);
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic restart();
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    chk("restart_clk", int'(clk_out), 0);
    chk("restart_tick", int'(tick_out), 0);
    rise = '{0, 0, 0};
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) if (clk_out[c] && rise[c] == 0) rise[c] = k;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, a, b, c, t, fall;
    tbl[0] = '{1, 1, 1, 1, 2};
    tbl[1] = '{2, 2, 2, 2, 2};
    tbl[2] = '{7, 7, 7, 7, 2};
    tbl[3] = '{13, 13, 13, 13, 2};

    #12;
    chk("rst_clk", int'(clk_out), 0);
    chk("rst_tick", int'(tick_out), 0);
    @(negedge clk);
    rst_b = 1'b1;
    wait_lvl(0, 1'b1, n);
    chk("def_rise", n, 20);
    chk("def_tick_at_rise", int'(tick_out[0]), 1);
    t = 0;
    fall = 0;
    for (int k = 1; k <= 39; k++) begin
      @(negedge clk);
      t += int'(tick_out[0]);
      if (!clk_out[0] && fall == 0) fall = k;
    end
    chk("def_high", fall, 20);
    chk("def_ticks_in_period", t, 0);

    ch_en = 3'b000;
    wr(0, 5);
    ch_en = 3'b001;
    wait_lvl(0, 1'b1, n);
    chk("reload_first_rise", n, 5);
    repeat (2) @(negedge clk);
    wr(0, 3);
    wait_lvl(0, 1'b0, n);
    chk("reload_cur_half", n + 3, 5);
    wait_lvl(0, 1'b1, n);
    chk("reload_new_low", n, 3);
    wait_lvl(0, 1'b0, n);
    chk("reload_new_high", n, 3);
    repeat (2) @(negedge clk);
    wr(0, 2);
    chk("bypass_edge", int'(clk_out[0]), 1);
    wait_lvl(0, 1'b0, n);
    chk("bypass_half", n, 2);

    wr(1, 4);
    ch_en[1] = 1'b1;
    wait_lvl(1, 1'b1, n);
    chk("en_rise", n, 4);
    @(negedge clk);
    ch_en[1] = 1'b0;
    @(negedge clk);
    chk("dis_clk", int'(clk_out[1]), 0);
    chk("dis_tick", int'(tick_out[1]), 0);
    wr(1, 0);
    ch_en[1] = 1'b1;
    t = 0;
    repeat (10) begin
      @(negedge clk);
      t += int'(clk_out[1] | tick_out[1]);
    end
    chk("frozen_activity", t, 0);
    wr(1, 2);
    wait_lvl(1, 1'b1, n);
    chk("unfreeze_rise", n, 2);
    wait_lvl(1, 1'b0, n);
    chk("unfreeze_high", n, 2);

    for (int v = 0; v < 4; v++) begin
      ch_en[2] = 1'b0;
      wr(2, tbl[v].div);
      ch_en[2] = 1'b1;
      wait_lvl(2, 1'b1, a);
      wait_lvl(2, 1'b0, b);
      wait_lvl(2, 1'b1, c);
      chk($sformatf("tbl%0d_rise", v), a, tbl[v].rise);
      chk($sformatf("tbl%0d_high", v), b, tbl[v].hi);
      chk($sformatf("tbl%0d_low", v), c, tbl[v].lo);
      t = 0;
      repeat (4 * tbl[v].div) begin
        @(negedge clk);
        t += int'(tick_out[2]);
      end
      chk($sformatf("tbl%0d_ticks", v), t, tbl[v].tk);
    end

    ch_en = 3'b000;
    wr(0, 4);
    wr(1, 6);
    wr(2, 10);
    ch_en = 3'b111;
    repeat (17) @(negedge clk);
    restart();
    chk("align_rise0", rise[0], 4);
    chk("align_rise1", rise[1], 6);
    chk("align_rise2", rise[2], 10);

    wr(3, 1);
    restart();
    chk("badch_rise0", rise[0], 4);
    chk("badch_rise1", rise[1], 6);
    chk("badch_rise2", rise[2], 10);

    wait_lvl(0, 1'b1, n);
    chk("pre_reset_high", int'(clk_out[0]), 1);
    #2 rst_b = 1'b0;
    #1;
    chk("async_rst_clk", int'(clk_out), 0);
    chk("async_rst_tick", int'(tick_out), 0);
    @(negedge clk);
    rst_b = 1'b1;
    wait_lvl(0, 1'b1, n);
    chk("post_rst_rise", n, 20);
    chk("post_rst_all", int'(clk_out), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
